stream_to_memory: RTL and testbench

STREAM_TO_MEMORY -- requirements
Module: stream_to_memory

---
 rtl/stream_to_memory.sv | 69 ++++++
 tb/tb_stream_to_memory.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/stream_to_memory.sv
// Collects a stream of words into a frame register bank and presents the whole
// frame downstream once it is full or the upstream marks the end of a window.
module stream_to_memory #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned MEMORY_DEPTH = 20
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  rts_i,
  output logic                                  rtr_o,
  input  logic                                  eow_i,
  input  logic [DATA_WIDTH-1:0]                 data_i,
  input  logic                                  rtr_i,
  output logic                                  rts_o,
  output logic                                  eow_o,
  output logic [DATA_WIDTH-1:0]                 data_o [MEMORY_DEPTH-1:0],
  output logic [$clog2(MEMORY_DEPTH+1)-1:0]     count_o
);

  localparam int unsigned PTR_W = $clog2(MEMORY_DEPTH);
  localparam int unsigned CNT_W = $clog2(MEMORY_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(MEMORY_DEPTH - 1);

  typedef enum logic {FILL, FULL} state_t;

  state_t           state;
  logic [PTR_W-1:0] wr_ptr;

  // Handshake outputs are pure decodes of the state register.
  assign rtr_o = (state == FILL);
  assign rts_o = (state == FULL);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= FILL;
      wr_ptr  <= '0;
      eow_o   <= 1'b0;
      count_o <= '0;
      for (int unsigned i = 0; i < MEMORY_DEPTH; i++) data_o[i] <= '0;
    end else begin
      case (state)
        FILL: begin
          if (rts_i && rtr_o) begin
            data_o[wr_ptr] <= data_i;
            // The pointer parks on the last written entry; the handoff clears it.
            if (wr_ptr == LAST || eow_i) begin
              state   <= FULL;
              eow_o   <= eow_i;
              count_o <= CNT_W'(wr_ptr) + CNT_W'(1);
            end else begin
              wr_ptr <= wr_ptr + PTR_W'(1);
            end
          end
        end
        FULL: begin
          if (rtr_i) begin
            state   <= FILL;
            wr_ptr  <= '0;
            eow_o   <= 1'b0;
            count_o <= '0;
            for (int unsigned i = 0; i < MEMORY_DEPTH; i++) data_o[i] <= '0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_to_memory.sv
// Bench for stream_to_memory (DATA_WIDTH=16, MEMORY_DEPTH=4): fixed vectors,
// directed corner sequences and a randomized run against a queue-based model.
module tb_stream_to_memory;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n, rts_i, eow_i, rtr_i;
  logic [DW-1:0] data_i;
  logic          rtr_o, rts_o, eow_o;
  logic [DW-1:0] data_o [DEPTH-1:0];
  logic [2:0]    count_o;

  int total = 0;
  int bad   = 0;

  stream_to_memory #(.DATA_WIDTH(DW), .MEMORY_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .rts_i(rts_i), .rtr_o(rtr_o), .eow_i(eow_i),
    .data_i(data_i), .rtr_i(rtr_i), .rts_o(rts_o), .eow_o(eow_o),
    .data_o(data_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  // Model: a frame is the list of words received so far; it is presented once
  // it holds DEPTH words or a word carrying eow arrived.
  bit          m_full = 1'b0;
  bit          m_eow  = 1'b0;
  logic [DW-1:0] m_q [$];

  task automatic model_step();
    if (!rst_n) begin
      m_full = 1'b0; m_eow = 1'b0; m_q.delete();
    end else if (!m_full) begin
      if (rts_i) begin
        m_q.push_back(data_i);
        if (m_q.size() == DEPTH || eow_i) begin
          m_full = 1'b1; m_eow = eow_i;
        end
      end
    end else if (rtr_i) begin
      m_full = 1'b0; m_eow = 1'b0; m_q.delete();
    end
  endtask

  function automatic logic [63:0] dut_frame();
    return {data_o[3], data_o[2], data_o[1], data_o[0]};
  endfunction

  function automatic logic [63:0] model_frame();
    logic [63:0] f = '0;
    for (int i = 0; i < m_q.size(); i++) f[i*DW +: DW] = m_q[i];
    return f;
  endfunction

  task automatic drive(input bit r, input bit s, input bit e, input bit t, input logic [DW-1:0] d);
    rst_n = r; rts_i = s; eow_i = e; rtr_i = t; data_i = d;
  endtask

  // Model advances on the pre-edge inputs; outputs are sampled 1 time unit later.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".rtr_o"}, 64'(rtr_o), 64'(!m_full));
    chk({tag, ".rts_o"}, 64'(rts_o), 64'(m_full));
    chk({tag, ".eow_o"}, 64'(eow_o), 64'(m_full ? m_eow : 1'b0));
    chk({tag, ".count_o"}, 64'(count_o), m_full ? 64'(m_q.size()) : 64'd0);
    chk({tag, ".data_o"}, dut_frame(), model_frame());
  endtask

  typedef struct {
    bit          rst_n, rts, eow, rtr;
    logic [15:0] data;
    bit          x_rtr, x_rts, x_eow;
    logic [2:0]  x_count;
    logic [63:0] x_data;
  } vec_t;

  vec_t vecs [11];
  logic [63:0] frozen;

  initial begin
    vecs = '{
      '{0, 0, 0, 0, 16'h0000, 1, 0, 0, 3'd0, 64'h0},
      '{1, 1, 0, 1, 16'h0011, 1, 0, 0, 3'd0, 64'h0000_0000_0000_0011},
      '{1, 1, 0, 1, 16'h0022, 1, 0, 0, 3'd0, 64'h0000_0000_0022_0011},
      '{1, 1, 0, 1, 16'h0033, 1, 0, 0, 3'd0, 64'h0000_0033_0022_0011},
      '{1, 1, 0, 1, 16'h0044, 0, 1, 0, 3'd4, 64'h0044_0033_0022_0011},
      '{1, 0, 0, 1, 16'h0000, 1, 0, 0, 3'd0, 64'h0},
      '{1, 1, 0, 1, 16'h00A1, 1, 0, 0, 3'd0, 64'h0000_0000_0000_00A1},
      '{1, 1, 1, 1, 16'h00A2, 0, 1, 1, 3'd2, 64'h0000_0000_00A2_00A1},
      '{1, 0, 0, 1, 16'h0000, 1, 0, 0, 3'd0, 64'h0},
      '{1, 1, 1, 0, 16'h0055, 0, 1, 1, 3'd1, 64'h0000_0000_0000_0055},
      '{1, 0, 0, 1, 16'h0000, 1, 0, 0, 3'd0, 64'h0}
    };

    drive(0, 0, 0, 0, '0);
    #1;
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].rst_n, vecs[i].rts, vecs[i].eow, vecs[i].rtr, vecs[i].data);
      step();
      chk($sformatf("vec%0d.rtr_o", i), 64'(rtr_o), 64'(vecs[i].x_rtr));
      chk($sformatf("vec%0d.rts_o", i), 64'(rts_o), 64'(vecs[i].x_rts));
      chk($sformatf("vec%0d.eow_o", i), 64'(eow_o), 64'(vecs[i].x_eow));
      chk($sformatf("vec%0d.count_o", i), 64'(count_o), 64'(vecs[i].x_count));
      chk($sformatf("vec%0d.data_o", i), dut_frame(), vecs[i].x_data);
    end

    // Downstream backpressure: frame held for 10 cycles while upstream keeps pushing.
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0, 0, 16'h0100 + 16'(i));
      step();
      check_model("bp_fill");
    end
    frozen = dut_frame();
    chk("bp_frame", frozen, 64'h0103_0102_0101_0100);
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, $urandom_range(1), 0, 16'($urandom));
      step();
      check_model("bp_hold");
      chk("bp_frozen", dut_frame(), frozen);
    end
    drive(1, 1, 0, 1, 16'h0BAD);
    step();
    check_model("bp_handoff");
    drive(1, 1, 0, 0, 16'h0200);
    step();
    check_model("bp_next");
    chk("bp_entry0", 64'(data_o[0]), 64'h0200);

    // Upstream gaps: only qualified words land, in order.
    drive(0, 0, 0, 0, '0);
    step();
    begin
      bit pat [7] = '{1, 0, 0, 1, 1, 0, 1};
      for (int i = 0; i < 7; i++) begin
        drive(1, pat[i], 0, 0, 16'h0300 + 16'(i));
        step();
        check_model("gap");
      end
    end
    chk("gap_frame", dut_frame(), 64'h0306_0304_0303_0300);
    chk("gap_count", 64'(count_o), 64'd4);

    // Mid-frame reset discards the partial frame.
    drive(1, 0, 0, 1, '0);
    step();
    drive(1, 1, 0, 0, 16'h0401); step();
    drive(1, 1, 0, 0, 16'h0402); step();
    drive(0, 1, 0, 0, 16'h0403); step();
    check_model("mid_rst");
    chk("mid_rst_rtr", 64'(rtr_o), 64'd1);
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0, 0, 16'h0500 + 16'(i));
      step();
      check_model("post_rst");
    end
    chk("post_rst_frame", dut_frame(), 64'h0503_0502_0501_0500);

    // Reset in FULL with and without a simultaneous handoff request.
    drive(0, 0, 0, 1, '0); step();
    check_model("rst_full_rtr1");
    chk("rst_full_rts", 64'(rts_o), 64'd0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0, 0, 16'h0600 + 16'(i)); step();
    end
    drive(0, 0, 0, 0, '0); step();
    check_model("rst_full_rtr0");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(39) != 0, $urandom_range(3) != 0, $urandom_range(5) == 0,
            $urandom_range(1) == 1, 16'($urandom));
      step();
      check_model("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
